// File: rtl/cam_pkg.sv
// Shared definitions for the camera pixel capture path.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FE,
        ST_ACTIVE
    } cam_state_e;

    localparam int unsigned SYNC_STAGES       = 2;
    localparam int unsigned MAX_BYTES_PER_PIX = 4;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser plus one history flop for rise/fall pulses.
// q is stage 2; edges compare stage 2 against stage 3.
module cam_sync_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign q    = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera pin oversampler, byte-to-pixel assembler, crop/decimate filter
// and single-entry valid/ready output register with drop accounting.
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int unsigned DB_WIDTH      = 8,
    parameter int unsigned BYTES_PER_PIX = 2,
    parameter int unsigned X_WIDTH       = 11,
    parameter int unsigned Y_WIDTH       = 10,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              cmos_pclk,
    input  logic                              cmos_href,
    input  logic                              cmos_vsync,
    input  logic [DB_WIDTH-1:0]               cmos_db,
    input  logic [X_WIDTH-1:0]                crop_x0,
    input  logic [X_WIDTH-1:0]                crop_x1,
    input  logic [Y_WIDTH-1:0]                crop_y0,
    input  logic [Y_WIDTH-1:0]                crop_y1,
    input  logic [1:0]                        decim,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DB_WIDTH*BYTES_PER_PIX-1:0] m_data,
    output logic                              m_sof,
    output logic                              m_eol,
    output logic [CNT_WIDTH-1:0]              frame_cnt,
    output logic [CNT_WIDTH-1:0]              drop_cnt,
    output logic                              overflow,
    output logic                              busy
);

    localparam int unsigned PIX_W    = DB_WIDTH * BYTES_PER_PIX;
    localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_PIX - 1);

    logic [2:0]          ctl_q, ctl_rise, ctl_fall;
    logic [DB_WIDTH-1:0] db_s, db_rise, db_fall;

    cam_sync_edge #(.WIDTH(3)) u_sync_ctl (
        .clk  (clk),
        .rst  (rst),
        .d    ({cmos_vsync, cmos_href, cmos_pclk}),
        .q    (ctl_q),
        .rise (ctl_rise),
        .fall (ctl_fall)
    );

    cam_sync_edge #(.WIDTH(DB_WIDTH)) u_sync_db (
        .clk  (clk),
        .rst  (rst),
        .d    (cmos_db),
        .q    (db_s),
        .rise (db_rise),
        .fall (db_fall)
    );

    logic pclk_rise, href_s, href_fall, vs_rise, vs_fall;
    assign pclk_rise = ctl_rise[0];
    assign href_s    = ctl_q[1];
    assign href_fall = ctl_fall[1];
    assign vs_rise   = ctl_rise[2];
    assign vs_fall   = ctl_fall[2];

    cam_state_e          state_q, state_d;
    logic [1:0]          idx_q, idx_d, hph_q, hph_d, vph_q, vph_d, dec_q, dec_d;
    logic [X_WIDTH-1:0]  x_q, x_d, cx0_q, cx0_d, cx1_q, cx1_d;
    logic [Y_WIDTH-1:0]  y_q, y_d, cy0_q, cy0_d, cy1_q, cy1_d;
    logic [PIX_W-1:0]    sr_q, sr_d, m_data_q, m_data_d;
    logic                sof_arm_q, sof_arm_d, m_valid_q, m_valid_d;
    logic                m_sof_q, m_sof_d, m_eol_q, m_eol_d, overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

    logic [PIX_W+DB_WIDTH-1:0] cat;
    logic [PIX_W-1:0]          pix;
    logic [X_WIDTH:0]          eol_sum;
    logic                      complete, in_x, in_y, keep, eol;

    always_comb begin
        cat      = {sr_q, db_s};
        pix      = cat[PIX_W-1:0];
        complete = (state_q == ST_ACTIVE) && !vs_rise && pclk_rise && href_s
                   && (idx_q == LAST_IDX);
        in_x     = (x_q >= cx0_q) && (x_q <= cx1_q);
        in_y     = (y_q >= cy0_q) && (y_q <= cy1_q);
        keep     = complete && in_x && in_y && (hph_q == 2'd0) && (vph_q == 2'd0);
        eol_sum  = {1'b0, x_q} + {{(X_WIDTH-1){1'b0}}, dec_q} + (X_WIDTH+1)'(1);
        eol      = eol_sum > {1'b0, cx1_q};
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hph_d       = hph_q;
        vph_d       = vph_q;
        dec_d       = dec_q;
        x_d         = x_q;
        y_d         = y_q;
        cx0_d       = cx0_q;
        cx1_d       = cx1_q;
        cy0_d       = cy0_q;
        cy1_d       = cy1_q;
        sr_d        = sr_q;
        sof_arm_d   = sof_arm_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_FE;
            end
            ST_WAIT_FE: begin
                if (vs_fall) begin
                    if (enable) begin
                        state_d   = ST_ACTIVE;
                        cx0_d     = crop_x0;
                        cx1_d     = crop_x1;
                        cy0_d     = crop_y0;
                        cy1_d     = crop_y1;
                        dec_d     = decim;
                        x_d       = '0;
                        y_d       = '0;
                        idx_d     = '0;
                        hph_d     = '0;
                        vph_d     = '0;
                        sof_arm_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (vs_rise) begin
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                    state_d     = enable ? ST_WAIT_FE : ST_IDLE;
                end else begin
                    if (pclk_rise && href_s) begin
                        sr_d = pix;
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            if (x_q != '1) x_d = x_q + X_WIDTH'(1);
                            // Phase is anchored so that column crop_x0 is phase 0.
                            if (x_q >= cx0_q) hph_d = (hph_q == dec_q) ? 2'd0 : hph_q + 2'd1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                    if (href_fall) begin
                        idx_d = '0;
                        hph_d = '0;
                        if (x_q != '0) begin
                            x_d = '0;
                            if (y_q != '1) y_d = y_q + Y_WIDTH'(1);
                            if (y_q >= cy0_q) vph_d = (vph_q == dec_q) ? 2'd0 : vph_q + 2'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_sof_d    = m_sof_q;
        m_eol_d    = m_eol_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (keep && m_valid_q && !m_ready) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end else if (keep) begin
            m_valid_d = 1'b1;
            m_data_d  = pix;
            m_sof_d   = sof_arm_q;
            m_eol_d   = eol;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // sof stays armed across a dropped first pixel.
    logic sof_arm_final;
    assign sof_arm_final = (keep && !(m_valid_q && !m_ready)) ? 1'b0 : sof_arm_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hph_q       <= '0;
            vph_q       <= '0;
            dec_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cx0_q       <= '0;
            cx1_q       <= '0;
            cy0_q       <= '0;
            cy1_q       <= '0;
            sr_q        <= '0;
            sof_arm_q   <= 1'b0;
            frame_cnt_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_sof_q     <= 1'b0;
            m_eol_q     <= 1'b0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hph_q       <= hph_d;
            vph_q       <= vph_d;
            dec_q       <= dec_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cx0_q       <= cx0_d;
            cx1_q       <= cx1_d;
            cy0_q       <= cy0_d;
            cy1_q       <= cy1_d;
            sr_q        <= sr_d;
            sof_arm_q   <= sof_arm_final;
            frame_cnt_q <= frame_cnt_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_sof_q     <= m_sof_d;
            m_eol_q     <= m_eol_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_sof     = m_sof_q;
    assign m_eol     = m_eol_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == ST_ACTIVE);

    logic unused_ok;
    assign unused_ok = ^{ctl_q[0], ctl_q[2], ctl_rise[1], ctl_fall[0],
                         db_rise, db_fall, cat[PIX_W+DB_WIDTH-1:PIX_W]};

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench: directed camera frames push expected pixels, a monitor pops on each transfer.
module tb_cam_pixel_capture;

    logic        clk = 1'b0;
    logic        rst, enable, cmos_pclk, cmos_href, cmos_vsync, m_ready;
    logic [7:0]  cmos_db;
    logic [10:0] crop_x0, crop_x1;
    logic [9:0]  crop_y0, crop_y1;
    logic [1:0]  decim;
    logic        m_valid, m_sof, m_eol, overflow, busy;
    logic [15:0] m_data, frame_cnt, drop_cnt;

    always #5 clk = ~clk;

    cam_pixel_capture #(
        .DB_WIDTH(8), .BYTES_PER_PIX(2), .X_WIDTH(11), .Y_WIDTH(10), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cmos_pclk(cmos_pclk), .cmos_href(cmos_href), .cmos_vsync(cmos_vsync), .cmos_db(cmos_db),
        .crop_x0(crop_x0), .crop_x1(crop_x1), .crop_y0(crop_y0), .crop_y1(crop_y1), .decim(decim),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .busy(busy)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [7:0] b0(int x, int y);
        return 8'(y * 16 + x);
    endfunction

    function automatic logic [15:0] pix(int x, int y);
        return {b0(x, y), ~b0(x, y)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic s, input logic e);
        exp_t t;
        t.d = d; t.sof = s; t.eol = e;
        exp_q.push_back(t);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pixel: got data=%0h sof=%0b eol=%0b, none expected",
                         m_data, m_sof, m_eol);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pixel{data,sof,eol}", {13'b0, m_data, m_sof, m_eol},
                    {13'b0, mon_e.d, mon_e.sof, mon_e.eol});
            end
        end
    end

    task automatic cam_byte(input logic [7:0] b);
        cmos_db   = b;
        cmos_href = 1'b1;
        cmos_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cmos_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic cam_line(input int y, input int npix, input int extra, input bit cst);
        for (int x = 0; x < npix; x++) begin
            if (cst) begin
                cam_byte(8'hA1);
                cam_byte(8'hB2);
            end else begin
                cam_byte(b0(x, y));
                cam_byte(~b0(x, y));
            end
        end
        for (int e = 0; e < extra; e++) cam_byte(8'h5A);
        cmos_pclk = 1'b0;
        cmos_href = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_start(input int x0, input int x1, input int y0, input int y1, input int dc);
        crop_x0 = 11'(x0); crop_x1 = 11'(x1);
        crop_y0 = 10'(y0); crop_y1 = 10'(y1);
        decim   = 2'(dc);
        repeat (2) @(negedge clk);
        cmos_vsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        cmos_vsync = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; cmos_pclk = 1'b0; cmos_href = 1'b0; cmos_vsync = 1'b1;
        cmos_db = '0; m_ready = 1'b0; decim = '0;
        crop_x0 = '0; crop_x1 = '0; crop_y0 = '0; crop_y1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_flags", {29'b0, m_sof, m_eol, overflow}, 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        enable = 1'b1; m_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Full 4x2 frame, constant bytes
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) push(16'hA1B2, (x == 0 && y == 0), (x == 3));
        frame_start(0, 3, 0, 1, 0);
        #1 chk("busy_active", 32'(busy), 1);
        @(negedge clk);
        cam_line(0, 4, 0, 1);
        cam_line(1, 4, 0, 1);
        frame_end();
        chk("t1_frame_cnt", 32'(frame_cnt), 1);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Crop window x 1..2, y 1..1
        push(pix(1, 1), 1'b1, 1'b0);
        push(pix(2, 1), 1'b0, 1'b1);
        frame_start(1, 2, 1, 1, 0);
        for (int y = 0; y < 3; y++) cam_line(y, 4, 0, 0);
        frame_end();
        chk("t2_frame_cnt", 32'(frame_cnt), 2);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Decimation by 2 on an 8x4 frame
        for (int y = 0; y < 4; y += 2)
            for (int x = 0; x < 8; x += 2) push(pix(x, y), (x == 0 && y == 0), (x == 6));
        frame_start(0, 7, 0, 3, 1);
        for (int y = 0; y < 4; y++) cam_line(y, 8, 0, 0);
        frame_end();
        chk("t3_frame_cnt", 32'(frame_cnt), 3);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Stray trailing byte at line end must be discarded
        push(pix(0, 1), 1'b1, 1'b0);
        push(pix(1, 1), 1'b0, 1'b1);
        frame_start(0, 1, 1, 1, 0);
        cam_line(0, 2, 1, 0);
        cam_line(1, 2, 1, 0);
        cam_line(2, 2, 0, 0);
        frame_end();
        chk("t4_queue_empty", exp_q.size(), 0);

        // Backpressure: hold first pixel, drop the next two
        m_ready = 1'b0;
        push(pix(0, 0), 1'b1, 1'b0);
        frame_start(0, 2, 0, 0, 0);
        cam_line(0, 3, 0, 0);
        frame_end();
        #1;
        chk("t5_drop_cnt", 32'(drop_cnt), 2);
        chk("t5_overflow", 32'(overflow), 1);
        chk("t5_held_valid", 32'(m_valid), 1);
        chk("t5_held_data", 32'(m_data), 32'(pix(0, 0)));
        chk("t5_frame_cnt", 32'(frame_cnt), 5);
        @(negedge clk);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t5_valid_after_accept", 32'(m_valid), 0);
        chk("t5_queue_empty", exp_q.size(), 0);
        chk("t5_overflow_sticky", 32'(overflow), 1);
        @(negedge clk);

        // Enable dropped mid-frame: frame finishes, then no more capture
        push(pix(0, 0), 1'b1, 1'b0);
        push(pix(1, 0), 1'b0, 1'b1);
        push(pix(0, 1), 1'b0, 1'b0);
        push(pix(1, 1), 1'b0, 1'b1);
        frame_start(0, 1, 0, 1, 0);
        cam_line(0, 2, 0, 0);
        enable = 1'b0;
        cam_line(1, 2, 0, 0);
        frame_end();
        #1;
        chk("t6_frame_cnt", 32'(frame_cnt), 6);
        chk("t6_busy_idle", 32'(busy), 0);
        @(negedge clk);
        frame_start(0, 1, 0, 1, 0);
        #1 chk("t6_busy_no_capture", 32'(busy), 0);
        @(negedge clk);
        cam_line(0, 2, 0, 0);
        frame_end();
        chk("t6_frame_cnt_unchanged", 32'(frame_cnt), 6);
        chk("t6_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a line with a pixel held
        enable  = 1'b1;
        m_ready = 1'b0;
        repeat (4) @(negedge clk);
        frame_start(0, 3, 0, 0, 0);
        cam_byte(8'h77);
        cam_byte(8'h88);
        cam_byte(8'h99);
        #1 chk("t7_pre_valid", 32'(m_valid), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t7_rst_valid", 32'(m_valid), 0);
        chk("t7_rst_data", 32'(m_data), 0);
        chk("t7_rst_flags", {29'b0, m_sof, m_eol, overflow}, 0);
        chk("t7_rst_frame_cnt", 32'(frame_cnt), 0);
        chk("t7_rst_drop_cnt", 32'(drop_cnt), 0);
        chk("t7_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        cmos_href = 1'b0;
        cmos_pclk = 1'b0;
        repeat (4) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
